// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending controller: accumulates coin credit,
// vends once PRICE is reached or refunds on cancel, and counts completed vends.
module vending_machine_param #(
  parameter int PRICE    = 4,
  parameter int COIN_W   = 2,
  parameter int CREDIT_W = 4,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_coin_valid,
  input  logic [COIN_W-1:0]   io_coin_value,
  output logic                io_coin_ready,
  input  logic                io_cancel,
  input  logic                io_ack,
  output logic                io_valid,
  output logic                io_refund,
  output logic [CREDIT_W-1:0] io_change,
  output logic [CREDIT_W-1:0] io_credit,
  output logic [COUNT_W-1:0]  io_vend_count
);

  // The largest reachable sum is (PRICE-1) plus the largest coin; it must fit in the credit register.
  generate
    if (PRICE < 1 || PRICE > (2**CREDIT_W) - 1 ||
        (PRICE - 1) + ((2**COIN_W) - 1) >= (2**CREDIT_W)) begin : g_bad_params
      $error("vending_machine_param: PRICE/COIN_W/CREDIT_W combination can overflow credit");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_REFUND  = 2'd3
  } state_e;

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [COUNT_W-1:0]  COUNT_MAX = '1;

  state_e                state_q,  state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [COUNT_W-1:0]    count_q,  count_d;

  logic                  accept;
  logic [CREDIT_W-1:0]   coin_amt;
  logic [CREDIT_W-1:0]   sum;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    io_coin_ready = (state_q == S_IDLE) || (state_q == S_COLLECT);
    accept        = io_coin_ready && io_coin_valid;
    coin_amt      = accept ? CREDIT_W'(io_coin_value) : '0;
    sum           = credit_q + coin_amt;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    count_d  = count_q;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        credit_d = sum;
        if (io_cancel) begin
          // Cancel wins over a purchase, and the coin offered alongside it is refunded too.
          state_d = (sum != '0) ? S_REFUND : S_IDLE;
        end else if (sum >= PRICE_C) begin
          state_d = S_VEND;
        end else if (sum != '0) begin
          state_d = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VEND: begin
        if (io_ack) begin
          state_d  = S_IDLE;
          credit_d = '0;
          count_d  = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
        end
      end
      S_REFUND: begin
        if (io_ack) begin
          state_d  = S_IDLE;
          credit_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // All outputs decode registered state only, so nothing combinational reaches them from inputs
  // except coin_ready, which also depends on state alone.
  always_comb begin
    io_valid      = (state_q == S_VEND);
    io_refund     = (state_q == S_REFUND);
    io_change     = '0;
    if (state_q == S_VEND) begin
      io_change = credit_q - PRICE_C;
    end else if (state_q == S_REFUND) begin
      io_change = credit_q;
    end
    io_credit     = credit_q;
    io_vend_count = count_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: a credit/mode reference model predicts each cycle,
// a monitor compares per-cycle outputs and each vend/refund transaction.
module tb_vending_machine_param;

  localparam int PRICE = 4;

  typedef struct {
    int credit;
    int ready;
    int valid;
    int refund;
    int change;
    int count;
    int count2;
  } snap_t;

  typedef struct {
    int is_vend;
    int change;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_coin_valid;
  logic [1:0] io_coin_value;
  logic       io_cancel;
  logic       io_ack;

  logic       io_coin_ready, io_valid, io_refund;
  logic [3:0] io_change, io_credit;
  logic [7:0] io_vend_count;

  logic       c2_coin_ready, c2_valid, c2_refund;
  logic [3:0] c2_change, c2_credit;
  logic [1:0] c2_vend_count;

  int total = 0;
  int bad   = 0;

  snap_t exp_q[$];
  txn_t  txn_q[$];

  // Reference model: mode 0 = accepting coins, 1 = vending, 2 = refunding.
  int m_credit = 0;
  int m_mode   = 0;
  int m_count  = 0;
  int m_count2 = 0;

  vending_machine_param dut (
    .clk           (clk),
    .reset         (reset),
    .io_coin_valid (io_coin_valid),
    .io_coin_value (io_coin_value),
    .io_coin_ready (io_coin_ready),
    .io_cancel     (io_cancel),
    .io_ack        (io_ack),
    .io_valid      (io_valid),
    .io_refund     (io_refund),
    .io_change     (io_change),
    .io_credit     (io_credit),
    .io_vend_count (io_vend_count)
  );

  vending_machine_param #(.COUNT_W(2)) dut_c2 (
    .clk           (clk),
    .reset         (reset),
    .io_coin_valid (io_coin_valid),
    .io_coin_value (io_coin_value),
    .io_coin_ready (c2_coin_ready),
    .io_cancel     (io_cancel),
    .io_ack        (io_ack),
    .io_valid      (c2_valid),
    .io_refund     (c2_refund),
    .io_change     (c2_change),
    .io_credit     (c2_credit),
    .io_vend_count (c2_vend_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, queue the expectation.
  task automatic step(input bit cv, input logic [1:0] val, input bit cancel, input bit ack,
                      input bit rst);
    snap_t s;
    txn_t  t;
    int    nxt;
    @(negedge clk);
    io_coin_valid = cv;
    io_coin_value = val;
    io_cancel     = cancel;
    io_ack        = ack;
    reset         = rst;
    if (rst) begin
      m_credit = 0;
      m_mode   = 0;
      m_count  = 0;
      m_count2 = 0;
    end else if (m_mode == 0) begin
      nxt      = m_credit + (cv ? int'(val) : 0);
      m_credit = nxt;
      if (cancel) m_mode = (nxt > 0) ? 2 : 0;
      else if (nxt >= PRICE) m_mode = 1;
      if (m_mode != 0) begin
        t.is_vend = (m_mode == 1) ? 1 : 0;
        t.change  = (m_mode == 1) ? m_credit - PRICE : m_credit;
        txn_q.push_back(t);
      end
    end else if (ack) begin
      if (m_mode == 1) begin
        m_count  = (m_count  < 255) ? m_count + 1  : 255;
        m_count2 = (m_count2 < 3)   ? m_count2 + 1 : 3;
      end
      m_mode   = 0;
      m_credit = 0;
    end
    s.credit = m_credit;
    s.ready  = (m_mode == 0) ? 1 : 0;
    s.valid  = (m_mode == 1) ? 1 : 0;
    s.refund = (m_mode == 2) ? 1 : 0;
    s.change = (m_mode == 1) ? m_credit - PRICE : (m_mode == 2) ? m_credit : 0;
    s.count  = m_count;
    s.count2 = m_count2;
    exp_q.push_back(s);
  endtask

  // Monitor: one expectation per clock edge, plus a transaction check whenever an output appears.
  initial begin : monitor
    snap_t s;
    txn_t  t;
    bit    present;
    bit    prev_present = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("credit",     32'(io_credit),     s.credit);
        check("coin_ready", 32'(io_coin_ready), s.ready);
        check("valid",      32'(io_valid),      s.valid);
        check("refund",     32'(io_refund),     s.refund);
        check("change",     32'(io_change),     s.change);
        check("vend_count", 32'(io_vend_count), s.count);
        check("vend_count_w2", 32'(c2_vend_count), s.count2);
        present = (io_valid === 1'b1) || (io_refund === 1'b1);
        if (present && !prev_present) begin
          total++;
          if (txn_q.size() == 0) begin
            bad++;
            $display("FAIL txn_unexpected: got valid=%0b refund=%0b expected no transaction",
                     io_valid, io_refund);
          end else begin
            t = txn_q.pop_front();
            total--;
            check("txn_kind",   32'(io_valid),  t.is_vend);
            check("txn_change", 32'(io_change), t.change);
          end
        end
        prev_present = present;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    io_coin_valid = 1'b0;
    io_coin_value = 2'd0;
    io_cancel     = 1'b0;
    io_ack        = 1'b0;
    reset         = 1'b1;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Five vends of four unit coins, ack in the first vend cycle; narrow counter saturates at 3.
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < 4; c++) step(1, 2'd1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
    end

    // 3 + 3 -> vend with change 2; outputs held while ack stays low, coins ignored.
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 2'd3, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // Coin 2 then cancel -> refund of 2.
    step(1, 2'd2, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // Credit 1, then coin 3 with cancel -> refund 4 rather than vend; idle cancel is a no-op.
    step(1, 2'd1, 0, 0, 0);
    step(1, 2'd3, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // Reset during a pending vend discards it.
    step(1, 2'd2, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 2'd1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    check("drain_pending", 32'(exp_q.size()), 0);
    check("txn_left",      32'(txn_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
